// File: rtl/mem_test_gen.sv
// Burst traffic generator/checker for the aq_axi_master user-side burst interface.
// Writes N bursts of a selectable pattern, reads them back and counts mismatching beats.
module mem_test_gen #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 27,
  parameter int unsigned LEN_BITS      = 10,
  parameter int unsigned BURST_LEN     = 128,
  parameter logic [31:0] SEED          = 32'h1
) (
  input  logic                     M_AXI_ACLK,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic                     loop_en,
  input  logic [ADDR_BITS-1:0]     base_addr,
  input  logic [15:0]              num_bursts,
  output logic                     wr_burst_req,
  output logic [LEN_BITS-1:0]      wr_burst_len,
  output logic [31:0]              wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     rd_burst_req,
  output logic [LEN_BITS-1:0]      rd_burst_len,
  output logic [31:0]              rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              err_cnt,
  output logic [ADDR_BITS-1:0]     err_addr,
  output logic [15:0]              pass_cnt
);

  localparam int unsigned Lanes   = MEM_DATA_BITS / 32;
  localparam int unsigned CntBits = LEN_BITS + 1;
  localparam logic [31:0] Poly    = 32'h8020_0003;

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrWait, StRdReq, StRdWait, StNext, StDone
  } state_e;

  state_e                  state_q;
  logic [1:0]              mode_q;
  logic [ADDR_BITS-1:0]    base_q;
  logic [15:0]             num_q;
  logic [15:0]             burst_idx_q;
  logic [ADDR_BITS-1:0]    burst_addr_q;
  logic [CntBits-1:0]      wr_beat_q;
  logic [CntBits-1:0]      rd_beat_q;
  logic [31:0]             wr_lfsr_q;
  logic [31:0]             rd_lfsr_q;
  logic                    wr_active_q;
  logic                    wr_req_q;
  logic                    rd_req_q;
  logic [LEN_BITS-1:0]     len_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic [15:0]             err_cnt_q;
  logic [ADDR_BITS-1:0]    err_addr_q;
  logic [15:0]             pass_cnt_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? Poly : 32'h0);
  endfunction

  function automatic logic [MEM_DATA_BITS-1:0] pattern(input logic [1:0]           m,
                                                       input logic [ADDR_BITS-1:0] w,
                                                       input logic [31:0]          lfsr);
    logic [MEM_DATA_BITS-1:0] d;
    d = '0;
    unique case (m)
      2'b00: for (int i = 0; i < Lanes; i++) d[i*32 +: 32] = 32'(w);
      2'b01: d = MEM_DATA_BITS'(1) << (w % ADDR_BITS'(MEM_DATA_BITS));
      2'b10: for (int i = 0; i < Lanes; i++) d[i*32 +: 32] = lfsr;
      2'b11: d = {MEM_DATA_BITS{w[0]}};
    endcase
    return d;
  endfunction

  logic [ADDR_BITS-1:0]     wr_word, rd_word;
  logic [MEM_DATA_BITS-1:0] wr_pat, rd_exp;
  logic                     rd_take, rd_over, rd_bad;

  always_comb begin
    wr_word = burst_addr_q + ADDR_BITS'(wr_beat_q);
    rd_word = burst_addr_q + ADDR_BITS'(rd_beat_q);
    wr_pat  = pattern(mode_q, wr_word, wr_lfsr_q);
    rd_exp  = pattern(mode_q, rd_word, rd_lfsr_q);
    rd_take = (state_q == StRdWait) && rd_burst_data_valid;
    // Beats past the burst length are errors regardless of their data.
    rd_over = rd_beat_q >= CntBits'(BURST_LEN);
    rd_bad  = rd_take && (rd_over || (rd_burst_data != rd_exp));
  end

  always_ff @(posedge M_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= 2'b00;
      base_q       <= '0;
      num_q        <= '0;
      burst_idx_q  <= '0;
      burst_addr_q <= '0;
      wr_beat_q    <= '0;
      rd_beat_q    <= '0;
      wr_lfsr_q    <= '0;
      rd_lfsr_q    <= '0;
      wr_active_q  <= 1'b0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_cnt_q    <= '0;
      err_addr_q   <= '0;
      pass_cnt_q   <= '0;
    end else begin
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;

      if (rd_bad) begin
        error_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        if (!error_q) err_addr_q <= rd_word;
      end
      if (rd_take) begin
        rd_lfsr_q <= lfsr_step(rd_lfsr_q);
        if (!rd_over) rd_beat_q <= rd_beat_q + CntBits'(1);
      end
      if ((state_q == StWrWait) && wr_burst_data_req) begin
        wr_beat_q <= wr_beat_q + CntBits'(1);
        wr_lfsr_q <= lfsr_step(wr_lfsr_q);
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q       <= mode;
            base_q       <= base_addr;
            num_q        <= num_bursts;
            burst_idx_q  <= '0;
            burst_addr_q <= base_addr;
            len_q        <= LEN_BITS'(BURST_LEN);
            error_q      <= 1'b0;
            err_cnt_q    <= '0;
            err_addr_q   <= '0;
            pass_cnt_q   <= '0;
            busy_q       <= 1'b1;
            if (num_bursts == 16'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StWrReq;
              wr_req_q <= 1'b1;
            end
          end
        end
        StWrReq: begin
          // Address is settled here, so the per-burst generator is reloaded now.
          wr_beat_q   <= '0;
          wr_lfsr_q   <= SEED ^ 32'(burst_addr_q);
          wr_active_q <= 1'b1;
          state_q     <= StWrWait;
        end
        StWrWait: begin
          if (wr_burst_finish) begin
            wr_active_q <= 1'b0;
            state_q     <= StRdReq;
            rd_req_q    <= 1'b1;
          end
        end
        StRdReq: begin
          rd_beat_q <= '0;
          rd_lfsr_q <= SEED ^ 32'(burst_addr_q);
          state_q   <= StRdWait;
        end
        StRdWait: begin
          if (rd_burst_finish) state_q <= StNext;
        end
        StNext: begin
          if ((burst_idx_q + 16'd1) == num_q) begin
            pass_cnt_q <= pass_cnt_q + 16'd1;
            if (loop_en && !stop) begin
              burst_idx_q  <= '0;
              burst_addr_q <= base_q;
              state_q      <= StWrReq;
              wr_req_q     <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else if (stop) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            burst_idx_q  <= burst_idx_q + 16'd1;
            burst_addr_q <= burst_addr_q + ADDR_BITS'(BURST_LEN);
            state_q      <= StWrReq;
            wr_req_q     <= 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_burst_req  = wr_req_q;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_len  = len_q;
  assign rd_burst_len  = len_q;
  assign wr_burst_addr = 32'(burst_addr_q);
  assign rd_burst_addr = 32'(burst_addr_q);
  // Data is forced low outside a write burst so reset and idle show all-zero outputs.
  assign wr_burst_data = wr_active_q ? wr_pat : '0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_cnt       = err_cnt_q;
  assign err_addr      = err_addr_q;
  assign pass_cnt      = pass_cnt_q;

endmodule

// File: tb/tb_mem_test_gen.sv
// Self-checking bench for mem_test_gen: burst slave model with memory, pattern reference
// model, vector table plus hand sequences for loop, stop, zero-burst and reset cases.
module tb_mem_test_gen;

  localparam int          BL   = 128;
  localparam logic [31:0] SEED = 32'h1;
  localparam int          NV   = 9;

  logic        clk, rst_n, start, stop, loop_en;
  logic [1:0]  mode;
  logic [26:0] base_addr;
  logic [15:0] num_bursts;
  logic        wr_burst_req, wr_burst_data_req, wr_burst_finish;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic [31:0] wr_burst_addr, rd_burst_addr;
  logic [63:0] wr_burst_data, rd_burst_data;
  logic        rd_burst_req, rd_burst_data_valid, rd_burst_finish;
  logic        busy, done, error;
  logic [15:0] err_cnt, pass_cnt;
  logic [26:0] err_addr;

  mem_test_gen #(
    .MEM_DATA_BITS(64), .ADDR_BITS(27), .LEN_BITS(10), .BURST_LEN(BL), .SEED(SEED)
  ) dut (
    .M_AXI_ACLK(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .loop_en(loop_en), .base_addr(base_addr), .num_bursts(num_bursts),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .rd_burst_req(rd_burst_req),
    .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish), .busy(busy), .done(done), .error(error),
    .err_cnt(err_cnt), .err_addr(err_addr), .pass_cnt(pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [26:0] base;
    int          nb;
    int          cb;
    int          cbeat;
    int          extra;
    bit          poke;
    int          exp_cnt;
    logic [26:0] exp_addr;
  } vec_t;

  vec_t        vecs [NV];
  int          checks = 0, errors = 0;
  logic [1:0]  tb_mode;
  logic [26:0] tb_base, last_wr_addr;
  int          tb_nb = 1, cb = -1, cbeat = 0, extra = 0;
  int          wr_cnt = 0, rd_cnt = 0;
  logic [63:0] mem [int unsigned];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern of beat j in a burst at address a, straight from the pattern definitions.
  function automatic logic [63:0] model_word(input logic [1:0] m, input logic [26:0] a,
                                             input int j);
    logic [26:0] w;
    logic [31:0] s;
    w = a + 27'(j);
    case (m)
      2'd0: return {5'b0, w, 5'b0, w};
      2'd1: return 64'd1 << (w % 64);
      2'd2: begin
        s = SEED ^ {5'b0, a};
        for (int i = 0; i < j; i++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        return {s, s};
      end
      default: return w[0] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [26:0] b, input int nb,
                              input int c, input int cbt, input int ex, input bit pk);
    vec_t v;
    v.mode = m; v.base = b; v.nb = nb; v.cb = c; v.cbeat = cbt; v.extra = ex; v.poke = pk;
    v.exp_cnt  = (c >= 0 ? 1 : 0) + ex * nb;
    v.exp_addr = '0;
    if (c >= 0) v.exp_addr = b + 27'(c * BL + cbt);
    else if (ex > 0) v.exp_addr = b + 27'(BL);
    return v;
  endfunction

  task automatic do_write();
    logic [26:0] a, ea;
    int len;
    a   = wr_burst_addr[26:0];
    len = int'(wr_burst_len);
    ea  = tb_base + 27'((wr_cnt % tb_nb) * BL);
    check("wr_addr", wr_burst_addr, {5'b0, ea});
    check("wr_len", wr_burst_len, BL);
    wr_cnt++;
    last_wr_addr = a;
    tick();
    for (int j = 0; j < len; j++) begin
      while ($urandom_range(0, 3) == 0) begin
        tick();
        if (!rst_n) return;
      end
      wr_burst_data_req = 1'b1;
      check("wr_data", wr_burst_data, model_word(tb_mode, a, j));
      mem[32'(a + 27'(j))] = wr_burst_data;
      tick();
      wr_burst_data_req = 1'b0;
      if (!rst_n) return;
    end
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
  endtask

  task automatic do_read();
    logic [26:0] a;
    logic [63:0] d;
    int len, bi;
    a   = rd_burst_addr[26:0];
    len = int'(rd_burst_len);
    check("rd_addr", rd_burst_addr, {5'b0, last_wr_addr});
    bi = rd_cnt;
    rd_cnt++;
    tick();
    for (int j = 0; j < len + extra; j++) begin
      while ($urandom_range(0, 3) == 0) begin
        tick();
        if (!rst_n) return;
      end
      d = mem.exists(32'(a + 27'(j))) ? mem[32'(a + 27'(j))] : 64'h0;
      if (bi == cb && j == cbeat) d[0] = ~d[0];
      rd_burst_data       = d;
      rd_burst_data_valid = 1'b1;
      tick();
      rd_burst_data_valid = 1'b0;
      if (!rst_n) return;
    end
    rd_burst_finish = 1'b1;
    tick();
    rd_burst_finish = 1'b0;
  endtask

  initial begin : slave
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_data       = '0;
    rd_burst_finish     = 1'b0;
    forever begin
      if (rst_n === 1'b1 && wr_burst_req === 1'b1) do_write();
      else if (rst_n === 1'b1 && rd_burst_req === 1'b1) do_read();
      else tick();
    end
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) break;
    end
    check("done_pulse", done, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_req"}, wr_burst_req, 0);
    check({tag, "_rd_req"}, rd_burst_req, 0);
    check({tag, "_wr_len"}, wr_burst_len, 0);
    check({tag, "_rd_len"}, rd_burst_len, 0);
    check({tag, "_wr_addr"}, wr_burst_addr, 0);
    check({tag, "_rd_addr"}, rd_burst_addr, 0);
    check({tag, "_wr_data"}, wr_burst_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_err_addr"}, err_addr, 0);
    check({tag, "_pass_cnt"}, pass_cnt, 0);
  endtask

  task automatic setup(input logic [1:0] m, input logic [26:0] b, input int nb,
                       input int c, input int cbt, input int ex);
    tb_mode = m; tb_base = b; tb_nb = (nb == 0) ? 1 : nb;
    cb = c; cbeat = cbt; extra = ex;
    wr_cnt = 0; rd_cnt = 0;
    mode = m; base_addr = b; num_bursts = 16'(nb);
  endtask

  task automatic run_vec(input vec_t v);
    setup(v.mode, v.base, v.nb, v.cb, v.cbeat, v.extra);
    loop_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("req_latency", wr_burst_req, 1'b1);
    check("busy_run", busy, 1'b1);
    if (v.poke) begin
      repeat (10) tick();
      base_addr = 27'h12345; num_bursts = 16'd7; mode = 2'b11;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done(20000);
    check("wr_bursts", wr_cnt, v.nb);
    check("rd_bursts", rd_cnt, v.nb);
    check("err_cnt", err_cnt, 64'(v.exp_cnt));
    check("error", error, v.exp_cnt != 0);
    check("err_addr", err_addr, v.exp_addr);
    check("pass_cnt", pass_cnt, 1);
    tick();
    check("busy_after", busy, 1'b0);
    check("done_width", done, 1'b0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin : driver
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    mode = 2'b00; base_addr = '0; num_bursts = '0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    vecs[0] = mk(2'd0, 27'd0, 4, -1, 0, 0, 1'b0);
    vecs[1] = mk(2'd0, 27'd0, 4, 2, 5, 0, 1'b0);
    vecs[2] = mk(2'd2, 27'h7FF_FFC0, 2, -1, 0, 0, 1'b0);
    vecs[3] = mk(2'd1, 27'h7FF_FFC0, 2, -1, 0, 0, 1'b0);
    vecs[4] = mk(2'd3, 27'd1000, 1, -1, 0, 2, 1'b0);
    vecs[5] = mk(2'd0, 27'd512, 2, -1, 0, 0, 1'b1);
    for (int i = 6; i < NV; i++) begin
      int nb;
      nb = int'($urandom_range(1, 2));
      if ($urandom_range(0, 1) == 1)
        vecs[i] = mk(2'($urandom_range(0, 3)), 27'($urandom), nb,
                     int'($urandom_range(0, nb - 1)), int'($urandom_range(0, BL - 1)), 0, 1'b0);
      else
        vecs[i] = mk(2'($urandom_range(0, 3)), 27'($urandom), nb, -1, 0, 0, 1'b0);
    end
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Zero bursts: done right away; a start coinciding with done is dropped.
    setup(2'd0, 27'd0, 0, -1, 0, 0);
    start = 1'b1;
    tick();
    check("zero_done", done, 1'b1);
    check("zero_no_req", wr_burst_req, 1'b0);
    num_bursts = 16'd1;
    tick();
    start = 1'b0;
    check("start_on_done_busy", busy, 1'b0);
    check("start_on_done_req", wr_burst_req, 1'b0);
    repeat (5) tick();
    check("zero_wr_bursts", wr_cnt, 0);
    check("zero_rd_bursts", rd_cnt, 0);

    // Loop mode, stop raised while the first write of pass 3 is in flight.
    setup(2'd2, 27'd4096, 2, -1, 0, 0);
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40000 && wr_cnt < 5; i++) tick();
    check("loop_reach_pass3", wr_cnt, 5);
    stop = 1'b1;
    wait_done(5000);
    check("loop_wr_bursts", wr_cnt, 5);
    check("loop_rd_bursts", rd_cnt, 5);
    check("loop_pass_cnt", pass_cnt, 2);
    check("loop_err_cnt", err_cnt, 0);
    stop = 1'b0;
    loop_en = 1'b0;
    tick();

    // Reset while a read burst is streaming.
    setup(2'd3, 27'd0, 2, -1, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5000 && rd_cnt < 1; i++) tick();
    check("reach_read", rd_cnt, 1);
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    check_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
